vram_fetch_seq: RTL and testbench

Parametrised video-memory byte sequencer for the CPC motherboard. It sits between the wide SDRAM video port and the gate array's 8-bit pixel data input. It replaces the fixed two-byte fetch logic with a generalised sequencer that does the following:
- serves BYTES bytes per video word, one per CAS strobe;
- provides a configurable byte-delay line for sync-filtered (shifted) display;
- flags strobe overruns.

---
 rtl/vram_fetch_seq_if.sv | 30 +++
 rtl/vram_fetch_seq.sv | 128 ++++++++++++
 tb/tb_vram_fetch_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_fetch_seq_if.sv
// Bus between the gate-array side and the VRAM byte sequencer.
// Width of vram_din and byte_idx follow BYTES.
interface vram_fetch_seq_if #(
   parameter int BYTES = 2
);
   localparam int IW = $clog2(BYTES);

   logic               cpu_n;
   logic               ras_n;
   logic               cas_n;
   logic               de;
   logic               shift_en;
   logic               overrun_clr;
   logic [8*BYTES-1:0] vram_din;
   logic [7:0]         vram_d;
   logic [IW-1:0]      byte_idx;
   logic               overrun;

   modport master (
      output cpu_n, ras_n, cas_n, de, shift_en,
      output overrun_clr, vram_din,
      input  vram_d, byte_idx, overrun
   );

   modport slave (
      input  cpu_n, ras_n, cas_n, de, shift_en,
      input  overrun_clr, vram_din,
      output vram_d, byte_idx, overrun
   );
endinterface

// File: rtl/vram_fetch_seq.sv
// VRAM byte sequencer: BYTES bytes per word, one per CAS strobe.
// Define VRAM_FETCH_SHIFT_EN to build the delay line and shift mode.
module vram_fetch_seq #(
   parameter int BYTES       = 2,
   parameter int SHIFT_DEPTH = 1
) (
   input logic             clk,
   input logic             reset_n,
   vram_fetch_seq_if.slave bus
);
   localparam int            IW   = $clog2(BYTES);
   localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      SAT
   } seq_t;

   seq_t          state;
   logic          cas_old;
   logic          cas_end;
   logic          upd;
   logic          push;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_d;
   logic          ovr_q;
   logic          ovr_d;
   logic [7:0]    vd_q;
   logic [7:0]    vd_d;
   logic [7:0]    cur_byte;
   logic [7:0]    din_b [BYTES];

   assign cas_end = !bus.ras_n & !cas_old & bus.cas_n;
   assign upd     = bus.cpu_n & !bus.ras_n & !bus.cas_n;

   always_comb begin
      for (int k = 0; k < BYTES; k++) begin
         din_b[k] = bus.vram_din[8*k +: 8];
      end
   end

   assign cur_byte = din_b[idx_q];

   always_comb begin
      state = SERVE;
      unique case (1'b1)
         (idx_q == LAST): state = SAT;
         (idx_q == '0):   state = IDLE;
         default:         state = SERVE;
      endcase
   end

   // CPU slot wins over a coincident strobe; a set wins over clear.
   always_comb begin
      idx_d = idx_q;
      ovr_d = ovr_q;
      push  = 1'b0;
      if (bus.overrun_clr) ovr_d = 1'b0;
      if (!bus.cpu_n) begin
         idx_d = '0;
      end else if (cas_end) begin
         push = 1'b1;
         unique case (state)
            SAT:     ovr_d = 1'b1;
            default: idx_d = idx_q + 1'b1;
         endcase
      end
   end

`ifdef VRAM_FETCH_SHIFT_EN
   logic [7:0] dly [SHIFT_DEPTH];
   logic [7:0] shf;
   int         pos;

   // Positions before the word start come from the byte pushed
   // SHIFT_DEPTH strobes ago, i.e. the tail of the delay line.
   always_comb begin
      pos = int'(idx_q) - SHIFT_DEPTH;
      shf = dly[SHIFT_DEPTH-1];
      if (pos >= 0) shf = din_b[pos[IW-1:0]];
   end

   always_comb begin
      vd_d = cur_byte;
      if (bus.shift_en) vd_d = shf;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < SHIFT_DEPTH; k++) begin
            dly[k] <= 8'h00;
         end
      end else if (push) begin
         dly[0] <= bus.de ? cur_byte : 8'h00;
         for (int k = 1; k < SHIFT_DEPTH; k++) begin
            dly[k] <= dly[k-1];
         end
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{bus.de, bus.shift_en, push, 1'(SHIFT_DEPTH)};

   always_comb begin
      vd_d = cur_byte;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cas_old <= 1'b1;
         idx_q   <= '0;
         ovr_q   <= 1'b0;
         vd_q    <= 8'h00;
      end else begin
         cas_old <= bus.cas_n;
         idx_q   <= idx_d;
         ovr_q   <= ovr_d;
         if (upd) vd_q <= vd_d;
      end
   end

   assign bus.vram_d   = vd_q;
   assign bus.byte_idx = idx_q;
   assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_vram_fetch_seq.sv
// Directed bench for vram_fetch_seq: a BYTES=2/DEPTH=1 and a
// BYTES=4/DEPTH=3 instance driven from one shared stimulus.
module tb_vram_fetch_seq;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_n, ras_n, cas_n, de, shift_en, overrun_clr;
   logic [15:0] din_a;
   logic [31:0] din_b;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   vram_fetch_seq_if #(.BYTES(2)) ia ();
   vram_fetch_seq_if #(.BYTES(4)) ib ();

   assign ia.cpu_n       = cpu_n;
   assign ia.ras_n       = ras_n;
   assign ia.cas_n       = cas_n;
   assign ia.de          = de;
   assign ia.shift_en    = shift_en;
   assign ia.overrun_clr = overrun_clr;
   assign ia.vram_din    = din_a;
   assign ib.cpu_n       = cpu_n;
   assign ib.ras_n       = ras_n;
   assign ib.cas_n       = cas_n;
   assign ib.de          = de;
   assign ib.shift_en    = shift_en;
   assign ib.overrun_clr = overrun_clr;
   assign ib.vram_din    = din_b;

   vram_fetch_seq #(.BYTES(2), .SHIFT_DEPTH(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ia.slave)
   );

   vram_fetch_seq #(.BYTES(4), .SHIFT_DEPTH(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ib.slave)
   );

   task automatic pulse(input logic d,
                        output logic [7:0] qa,
                        output logic [7:0] qb);
      @(negedge clk);
      de    = d;
      cas_n = 1'b0;
      @(negedge clk);
      qa    = ia.vram_d;
      qb    = ib.vram_d;
      cas_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic boundary();
      @(negedge clk);
      cpu_n = 1'b0;
      @(negedge clk);
      cpu_n = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         {cpu_n, ras_n, cas_n, de, shift_en, overrun_clr} = 6'($urandom);
         din_a = 16'($urandom);
         din_b = $urandom;
      end
      @(negedge clk);
      n_chk++;
      if (ia.vram_d !== 8'h00) $display("FAIL rst_vd_a got %h want 00", ia.vram_d);
      else n_pass++;
      n_chk++;
      if (ia.byte_idx !== 1'b0) $display("FAIL rst_idx_a got %h want 0", ia.byte_idx);
      else n_pass++;
      n_chk++;
      if (ia.overrun !== 1'b0) $display("FAIL rst_ovr_a got %b want 0", ia.overrun);
      else n_pass++;
      n_chk++;
      if (ib.vram_d !== 8'h00) $display("FAIL rst_vd_b got %h want 00", ib.vram_d);
      else n_pass++;
      n_chk++;
      if (ib.byte_idx !== 2'd0) $display("FAIL rst_idx_b got %h want 0", ib.byte_idx);
      else n_pass++;
      cpu_n = 1'b1; ras_n = 1'b0; cas_n = 1'b1; de = 1'b1;
      shift_en = 1'b0; overrun_clr = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_direct();
      logic [7:0] qa [4];
      logic [7:0] qb [4];
      logic [7:0] eb [4];
      shift_en = 1'b0;
      din_a = 16'hB7A5;
      din_b = 32'h44332211;
      eb = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) pulse(1'b1, qa[i], qb[i]);
      n_chk++;
      if (qa[0] !== 8'hA5) $display("FAIL direct_a0 got %h want a5", qa[0]);
      else n_pass++;
      n_chk++;
      if (qa[1] !== 8'hB7) $display("FAIL direct_a1 got %h want b7", qa[1]);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (qb[i] !== eb[i])
            $display("FAIL direct_b%0d got %h want %h", i, qb[i], eb[i]);
         else n_pass++;
      end
   endtask

   task automatic test_overrun();
      logic [7:0] qa, qb;
      shift_en = 1'b0;
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      boundary();
      repeat (3) pulse(1'b1, qa, qb);
      n_chk++;
      if (ia.byte_idx !== 1'b1) $display("FAIL ovr_idx_a got %h want 1", ia.byte_idx);
      else n_pass++;
      n_chk++;
      if (ia.overrun !== 1'b1) $display("FAIL ovr_set_a got %b want 1", ia.overrun);
      else n_pass++;
      n_chk++;
      if (ib.byte_idx !== 2'd3) $display("FAIL ovr_idx_b got %h want 3", ib.byte_idx);
      else n_pass++;
      n_chk++;
      if (ib.overrun !== 1'b0) $display("FAIL ovr_early_b got %b want 0", ib.overrun);
      else n_pass++;
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      n_chk++;
      if (ia.overrun !== 1'b0) $display("FAIL ovr_clr_a got %b want 0", ia.overrun);
      else n_pass++;
      n_chk++;
      if (ia.byte_idx !== 1'b1) $display("FAIL ovr_clr_idx got %h want 1", ia.byte_idx);
      else n_pass++;
      @(negedge clk); cas_n = 1'b0;
      @(negedge clk); cas_n = 1'b1; overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      n_chk++;
      if (ia.overrun !== 1'b1) $display("FAIL ovr_setwins_a got %b want 1", ia.overrun);
      else n_pass++;
      n_chk++;
      if (ib.overrun !== 1'b1) $display("FAIL ovr_setwins_b got %b want 1", ib.overrun);
      else n_pass++;
   endtask

   task automatic test_cpu_slot();
      logic [7:0] qa, qb;
      shift_en = 1'b0;
      din_a = 16'h2211;
      boundary();
      pulse(1'b1, qa, qb);
      n_chk++;
      if (qa !== 8'h11) $display("FAIL cpu_pre got %h want 11", qa);
      else n_pass++;
      @(negedge clk); cpu_n = 1'b0; cas_n = 1'b0;
      @(negedge clk); cas_n = 1'b1;
      @(negedge clk); cpu_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (ia.byte_idx !== 1'b0) $display("FAIL cpu_idx got %h want 0", ia.byte_idx);
      else n_pass++;
      n_chk++;
      if (ia.vram_d !== 8'h11) $display("FAIL cpu_hold got %h want 11", ia.vram_d);
      else n_pass++;
`ifdef VRAM_FETCH_SHIFT_EN
      shift_en = 1'b1;
      din_a = 16'h4433;
      pulse(1'b1, qa, qb);
      n_chk++;
      if (qa !== 8'h11) $display("FAIL cpu_nopush got %h want 11", qa);
      else n_pass++;
      shift_en = 1'b0;
`endif
   endtask

`ifdef VRAM_FETCH_SHIFT_EN
   task automatic test_shift_a();
      logic [7:0] qa [4];
      logic [7:0] qb;
      logic [7:0] e1 [4];
      logic [7:0] e2 [4];
      logic       dm [4];
      e1 = '{8'h00, 8'h11, 8'h22, 8'h33};
      e2 = '{8'h00, 8'h11, 8'h00, 8'h33};
      dm = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int r = 0; r < 2; r++) begin
         do_reset();
         shift_en = 1'b1;
         din_a = 16'h2211;
         pulse(1'b1, qa[0], qb);
         pulse(r == 0 ? 1'b1 : dm[1], qa[1], qb);
         boundary();
         din_a = 16'h4433;
         pulse(1'b1, qa[2], qb);
         pulse(1'b1, qa[3], qb);
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (qa[i] !== (r == 0 ? e1[i] : e2[i]))
               $display("FAIL shift_a_r%0d_%0d got %h want %h",
                        r, i, qa[i], (r == 0 ? e1[i] : e2[i]));
            else n_pass++;
         end
      end
      de = 1'b1;
   endtask

   task automatic test_shift_b();
      logic [7:0] qa;
      logic [7:0] qb [8];
      logic [7:0] eb [8];
      eb = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      do_reset();
      shift_en = 1'b1;
      din_b = 32'h44332211;
      for (int i = 0; i < 4; i++) pulse(1'b1, qa, qb[i]);
      boundary();
      din_b = 32'h88776655;
      for (int i = 4; i < 8; i++) pulse(1'b1, qa, qb[i]);
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (qb[i] !== eb[i])
            $display("FAIL shift_b%0d got %h want %h", i, qb[i], eb[i]);
         else n_pass++;
      end
      shift_en = 1'b0;
   endtask
`else
   task automatic test_no_shift_build();
      logic [7:0] qa [2];
      logic [7:0] qb [2];
      shift_en = 1'b1;
      din_a = 16'h2211;
      din_b = 32'h44332211;
      boundary();
      pulse(1'b0, qa[0], qb[0]);
      pulse(1'b0, qa[1], qb[1]);
      n_chk++;
      if (qa[0] !== 8'h11) $display("FAIL noshift_a0 got %h want 11", qa[0]);
      else n_pass++;
      n_chk++;
      if (qa[1] !== 8'h22) $display("FAIL noshift_a1 got %h want 22", qa[1]);
      else n_pass++;
      n_chk++;
      if (qb[1] !== 8'h22) $display("FAIL noshift_b1 got %h want 22", qb[1]);
      else n_pass++;
      shift_en = 1'b0;
      de = 1'b1;
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      cpu_n = 1'b1; ras_n = 1'b0; cas_n = 1'b1; de = 1'b1;
      shift_en = 1'b0; overrun_clr = 1'b0;
      din_a = '0; din_b = '0;
      test_reset();
      test_direct();
      test_overrun();
      test_cpu_slot();
`ifdef VRAM_FETCH_SHIFT_EN
      test_shift_a();
      test_shift_b();
`else
      test_no_shift_build();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
